// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage divider: FSM state encoding and
// counter sizing helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = count_width(DIV_WIDTH);

endpackage

// File: rtl/trial_subtractor.sv
// Combinational trial subtraction for restoring division, done as an add of
// the inverted zero-extended divisor with carry-in 1 (same scheme as ALU SUB).
module trial_subtractor #(
  parameter int N = 32
) (
  input  logic [N:0]   minuend,
  input  logic [N-1:0] divisor,
  output logic [N:0]   difference,
  output logic         no_borrow
);

  logic [N+1:0] sum;

  // Carry out of the (N+1)-bit add is the "no borrow" indication
  assign sum        = {1'b0, minuend} + {1'b0, ~{1'b0, divisor}} + {{(N+1){1'b0}}, 1'b1};
  assign difference = sum[N:0];
  assign no_borrow  = sum[N+1];

endmodule

// File: rtl/seq_mod_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock; the quotient is
// shifted into the dividend register as the dividend bits are consumed.
module seq_mod_divider
  import alu_pkg::*;
#(
  parameter int N = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = count_width(N);

  div_state_t   state;
  logic [CW-1:0] count;
  logic [N:0]   rem;
  logic [N-1:0] dq;
  logic [N-1:0] dsr;

  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic         no_borrow;
  logic [N:0]   rem_next;
  logic [N-1:0] dq_next;
  logic         unused_rem_msb;

  // rem stays below the divisor, so its top bit is always shifted out as zero
  assign shifted        = {rem[N-1:0], dq[N-1]};
  assign unused_rem_msb = rem[N];

  trial_subtractor #(.N(N)) u_trial (
    .minuend    (shifted),
    .divisor    (dsr),
    .difference (diff),
    .no_borrow  (no_borrow)
  );

  assign rem_next = no_borrow ? diff : shifted;
  assign dq_next  = {dq[N-2:0], no_borrow};

  // Control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= {CW{1'b0}};
      rem         <= {(N+1){1'b0}};
      dq          <= {N{1'b0}};
      dsr         <= {N{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {N{1'b0}};
      remainder   <= {N{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor != {N{1'b0}}) begin
              div_by_zero <= 1'b0;
              dq          <= dividend;
              dsr         <= divisor;
              rem         <= {(N+1){1'b0}};
              count       <= CW'(N - 1);
              state       <= CALC;
            end else begin
              div_by_zero <= 1'b1;
              quotient    <= {N{1'b1}};
              remainder   <= dividend;
              done        <= 1'b1;
              state       <= DONE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          rem <= rem_next;
          dq  <= dq_next;
          if (count == {CW{1'b0}}) begin
            quotient  <= dq_next;
            remainder <= rem_next[N-1:0];
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count - CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mod_divider.sv
// Self-checking bench for seq_mod_divider: table-driven operations through a
// result scoreboard, plus ignored-start, mid-operation reset and held-start runs.
module tb_seq_mod_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  seq_mod_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } res_t;

  res_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic compare_result(input string name);
    res_t e;
    if (sb.size() == 0) begin
      check({name, " scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, " quotient"}, quotient, e.q);
      check({name, " remainder"}, remainder, e.r);
      check({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.z});
    end
  endtask

  // Called at the first sample after the accepting edge (cycle 1).
  task automatic wait_done(input int poke, output int lat, output int busy_low);
    lat = 1;
    busy_low = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_low++;
      if (poke != 0 && lat == poke) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end else if (poke != 0 && lat == poke + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input vec_t v, input int poke);
    int lat;
    int busy_low;
    @(negedge clk);
    dividend = v.a; divisor = v.b; start = 1'b1;
    sb.push_back('{q: v.q, r: v.r, z: v.z});
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    wait_done(poke, lat, busy_low);
    check({name, " done_cycle"}, lat, v.lat);
    check({name, " busy_before_done"}, busy_low, 32'd0);
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd1);
    compare_result(name);
    @(negedge clk);
    check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
    check({name, " idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int   n_done;
    int   last_done;
    int   cyc;

    vecs[0] = '{a: 32'd100,        b: 32'd7,   q: 32'd14,         r: 32'd2,    z: 1'b0, lat: N + 1};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,   q: 32'hFFFF_FFFF,  r: 32'd0,    z: 1'b0, lat: N + 1};
    vecs[2] = '{a: 32'd5,          b: 32'd9,   q: 32'd0,          r: 32'd5,    z: 1'b0, lat: N + 1};
    vecs[3] = '{a: 32'd1234,       b: 32'd0,   q: 32'hFFFF_FFFF,  r: 32'd1234, z: 1'b1, lat: 1};
    vecs[4] = '{a: 32'd10,         b: 32'd3,   q: 32'd3,          r: 32'd1,    z: 1'b0, lat: N + 1};
    vecs[5] = '{a: 32'd65537,      b: 32'd257, q: 32'd255,        r: 32'd2,    z: 1'b0, lat: N + 1};
    vecs[6] = '{a: 32'h8000_0001,  b: 32'd3,   q: 32'h2AAA_AAAB,  r: 32'd0,    z: 1'b0, lat: N + 1};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i], 0);

    // Second start at cycle 10 must be ignored while calculating
    run_op("ignored_start", vecs[0], 10);

    // Asynchronous reset in the middle of a division
    @(negedge clk);
    dividend = 32'h8000_0000; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst quotient", quotient, 32'd0);
    check("midrst remainder", remainder, 32'd0);
    check("midrst div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("midrst no_done", n_done, 32'd0);
    run_op("after_rst", '{a: 32'd9, b: 32'd4, q: 32'd2, r: 32'd1, z: 1'b0, lat: N + 1}, 0);

    // start held high: one result every N+2 cycles
    @(negedge clk);
    dividend = 32'd65537; divisor = 32'd257; start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{q: 32'd255, r: 32'd2, z: 1'b0});
    n_done = 0; last_done = 0; cyc = 0;
    while (n_done < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        if (n_done == 0) check("held first_done", cyc, N + 1);
        else check("held interval", cyc - last_done, N + 2);
        compare_result($sformatf("held%0d", n_done));
        last_done = cyc;
        n_done++;
        if (n_done == 3) start = 1'b0;
      end
    end
    check("held done_count", n_done, 32'd3);
    repeat (3) @(negedge clk);
    check("held idle_after", {31'd0, busy}, 32'd0);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
